fft_frame_feeder: RTL and testbench

Ping-pong frame buffer between the audio capture path and the `xfft_1` FFT core. It collects 8-bit signed audio samples at the 12 kHz sample-valid rate into FRAME_LEN-sample frames. It streams each completed frame to the FFT slave data port as AXI-Stream, driving `tlast` on the final sample. This lets capture continue while the FFT applies backpressure. It replaces ad-hoc `fft_valid`/`fft_last` generation at top level.

---
 rtl/fft_frame_feeder.sv | 175 +++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer: captures FRAME_LEN audio samples per bank and streams
// each completed bank to the FFT as AXI-Stream with tlast on the final sample.
module fft_frame_feeder #(
   parameter int FRAME_LEN = 2048,
   parameter int ADDR_W    = 11
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        enable_in,
   input  logic        audio_valid_in,
   input  logic [7:0]  audio_in,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic [15:0] frame_count_out,
   output logic        drop_out,
   output logic        busy_out
);

   typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bank_e;
   typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rd_state_e;

   localparam logic [ADDR_W:0]   LEN_C    = (ADDR_W+1)'(FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   logic [7:0]        mem_q [0:2*FRAME_LEN-1];
   logic [7:0]        ram_rd_q;

   bank_e             bank_q [2];
   logic              wr_bank_q;
   logic [ADDR_W-1:0] wr_idx_q;

   rd_state_e         rd_state_q;
   logic              rd_bank_q;
   logic [ADDR_W:0]   rd_addr_q;
   logic              pend_q;
   logic              pend_last_q;
   logic              skid_vld_q;
   logic              skid_last_q;
   logic [7:0]        skid_data_q;
   logic              tvalid_q;
   logic              tlast_q;
   logic [7:0]        tdata_q;

   logic [15:0]       frame_cnt_q;
   logic              drop_q;
   logic              busy_q;

   logic              accept;
   logic              drop_evt;
   logic              pop;
   logic              issue;
   logic [1:0]        occ;

   always_comb begin
      accept   = enable_in && audio_valid_in && (bank_q[wr_bank_q] == B_EMPTY);
      drop_evt = enable_in && audio_valid_in && (bank_q[wr_bank_q] != B_EMPTY);
      pop      = tvalid_q && m_axis_tready;
      // Samples held in output+skid after this edge; a read issued now lands next cycle.
      occ      = 2'(tvalid_q) + 2'(skid_vld_q) + 2'(pend_q) - 2'(pop);
      issue    = 1'b0;
      if (rd_state_q == R_IDLE) begin
         issue = (bank_q[rd_bank_q] == B_FULL);
      end else begin
         issue = (rd_addr_q != LEN_C) && (occ <= 2'd1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) begin
         mem_q[{wr_bank_q, wr_idx_q}] <= audio_in;
      end
      ram_rd_q <= mem_q[{rd_bank_q, rd_addr_q[ADDR_W-1:0]}];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bank_q[0]   <= B_EMPTY;
         bank_q[1]   <= B_EMPTY;
         wr_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         rd_state_q  <= R_IDLE;
         rd_bank_q   <= 1'b0;
         rd_addr_q   <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_last_q <= 1'b0;
         skid_data_q <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tdata_q     <= '0;
         frame_cnt_q <= '0;
         drop_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (!enable_in) begin
            wr_idx_q <= '0;
         end else if (accept) begin
            if (wr_idx_q == LAST_IDX) begin
               bank_q[wr_bank_q] <= B_FULL;
               wr_idx_q          <= '0;
               wr_bank_q         <= ~wr_bank_q;
            end else begin
               wr_idx_q <= wr_idx_q + ADDR_W'(1);
            end
         end
         if (drop_evt) begin
            drop_q <= 1'b1;
         end

         pend_q <= issue;
         if (issue) begin
            rd_addr_q   <= rd_addr_q + (ADDR_W+1)'(1);
            pend_last_q <= (rd_addr_q[ADDR_W-1:0] == LAST_IDX);
         end

         // Output register refills from the skid slot first so order is preserved.
         if (!tvalid_q || pop) begin
            if (skid_vld_q) begin
               tdata_q     <= skid_data_q;
               tlast_q     <= skid_last_q;
               tvalid_q    <= 1'b1;
               skid_vld_q  <= pend_q;
               skid_data_q <= ram_rd_q;
               skid_last_q <= pend_last_q;
            end else if (pend_q) begin
               tdata_q  <= ram_rd_q;
               tlast_q  <= pend_last_q;
               tvalid_q <= 1'b1;
            end else begin
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
            end
         end else if (pend_q) begin
            skid_vld_q  <= 1'b1;
            skid_data_q <= ram_rd_q;
            skid_last_q <= pend_last_q;
         end

         case (rd_state_q)
            R_IDLE: begin
               if (issue) begin
                  bank_q[rd_bank_q] <= B_READING;
                  rd_state_q        <= R_PRIME;
               end
            end
            R_PRIME: begin
               rd_state_q <= R_STREAM;
            end
            R_STREAM: begin
               if (pop && tlast_q) begin
                  bank_q[rd_bank_q] <= B_EMPTY;
                  rd_bank_q         <= ~rd_bank_q;
                  rd_addr_q         <= '0;
                  frame_cnt_q       <= frame_cnt_q + 16'd1;
                  rd_state_q        <= R_IDLE;
               end
            end
            default: rd_state_q <= R_IDLE;
         endcase

         busy_q <= (bank_q[0] != B_EMPTY) || (bank_q[1] != B_EMPTY) || (rd_state_q != R_IDLE);
      end
   end

   assign m_axis_tdata    = {16'h0000, tdata_q, 8'h00};
   assign m_axis_tvalid   = tvalid_q;
   assign m_axis_tlast    = tlast_q;
   assign frame_count_out = frame_cnt_q;
   assign drop_out        = drop_q;
   assign busy_out        = busy_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with a 16-sample frame: latency, throughput,
// backpressure, overflow, ping-pong continuity, partial discard and mid-stream reset.
module tb_fft_frame_feeder;

   localparam int FL = 16;
   localparam int AW = 4;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable_in;
   logic        audio_valid_in;
   logic [7:0]  audio_in;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic [15:0] frame_count_out;
   logic        drop_out;
   logic        busy_out;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          rand_ready = 1'b0;

   logic [7:0]  expq[$];
   logic [31:0] got_data[$];
   logic        got_last[$];
   int          got_cyc[$];

   always #5 clk_in = ~clk_in;

   fft_frame_feeder #(.FRAME_LEN(FL), .ADDR_W(AW)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .enable_in       (enable_in),
      .audio_valid_in  (audio_valid_in),
      .audio_in        (audio_in),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
      .frame_count_out (frame_count_out),
      .drop_out        (drop_out),
      .busy_out        (busy_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: record a handshake that the coming edge completes, then
   // confirm that a stalled beat is held unchanged across the edge.
   task automatic tick();
      logic        stall;
      logic [31:0] hold_d;
      logic        hold_l;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      if (m_axis_tvalid && m_axis_tready) begin
         got_data.push_back(m_axis_tdata);
         got_last.push_back(m_axis_tlast);
         got_cyc.push_back(cyc);
      end
      stall  = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
      @(posedge clk_in);
      #1;
      cyc++;
      if (stall && !rst_in) begin
         chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
         chk("stall_data", m_axis_tdata, hold_d);
         chk("stall_last", 32'(m_axis_tlast), 32'(hold_l));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic strobe(input logic [7:0] s, input bit acc);
      audio_in       = s;
      audio_valid_in = 1'b1;
      tick();
      audio_valid_in = 1'b0;
      if (acc) expq.push_back(s);
   endtask

   task automatic drain(input int n, input int budget);
      int b = 0;
      while (got_data.size() < n && b < budget) begin
         tick();
         b++;
      end
      idle(6);
      chk("beat_count", 32'(got_data.size()), 32'(n));
   endtask

   task automatic check_beats(input string tag);
      int n = (got_data.size() < expq.size()) ? got_data.size() : expq.size();
      for (int k = 0; k < n; k++) begin
         chk({tag, "_data"}, got_data[k], {16'h0000, expq[k], 8'h00});
         chk({tag, "_last"}, 32'(got_last[k]), 32'((k % FL) == FL - 1));
      end
      expq.delete();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   initial begin
      rst_in         = 1'b1;
      enable_in      = 1'b0;
      audio_valid_in = 1'b0;
      audio_in       = 8'h00;
      m_axis_tready  = 1'b0;
      idle(3);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_frames", 32'(frame_count_out), 32'd0);
      chk("rst_drop", 32'(drop_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd0);
      rst_in = 1'b0;
      idle(2);

      // Basic frame: audio = i-8, tready high
      enable_in     = 1'b1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < FL; i++) strobe(8'(i - 8), 1'b1);
      chk("lat_n1_valid", 32'(m_axis_tvalid), 32'd0);
      tick();
      chk("lat_n2_valid", 32'(m_axis_tvalid), 32'd0);
      tick();
      chk("lat_n3_valid", 32'(m_axis_tvalid), 32'd1);
      chk("lat_n3_data", m_axis_tdata, 32'h0000F800);
      chk("busy_during", 32'(busy_out), 32'd1);
      drain(FL, 40);
      if (got_cyc.size() == FL) chk("throughput", 32'(got_cyc[FL-1] - got_cyc[0]), 32'(FL - 1));
      check_beats("basic");
      chk("basic_frames", 32'(frame_count_out), 32'd1);
      chk("basic_tvalid_off", 32'(m_axis_tvalid), 32'd0);
      chk("basic_busy_off", 32'(busy_out), 32'd0);

      // Backpressure: random tready during capture and streaming
      rand_ready = 1'b1;
      for (int i = 0; i < FL; i++) begin
         strobe(8'(3 * i + 1), 1'b1);
         idle(1);
      end
      drain(FL, 300);
      rand_ready    = 1'b0;
      m_axis_tready = 1'b1;
      check_beats("bp");
      chk("bp_frames", 32'(frame_count_out), 32'd2);

      // Overflow: both banks fill, the third frame's strobes are dropped
      m_axis_tready = 1'b0;
      for (int i = 0; i < 3 * FL; i++) begin
         strobe(8'(5 * i + 2), i < 2 * FL);
         if (i == 2 * FL - 1) chk("ovf_drop_before", 32'(drop_out), 32'd0);
      end
      chk("ovf_drop_after", 32'(drop_out), 32'd1);
      chk("ovf_busy", 32'(busy_out), 32'd1);
      chk("ovf_frames_held", 32'(frame_count_out), 32'd2);
      idle(5);
      m_axis_tready = 1'b1;
      drain(2 * FL, 100);
      idle(30);
      chk("ovf_no_third", 32'(got_data.size()), 32'(2 * FL));
      check_beats("ovf");
      chk("ovf_frames", 32'(frame_count_out), 32'd4);
      chk("ovf_drop_sticky", 32'(drop_out), 32'd1);

      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk("rst2_frames", 32'(frame_count_out), 32'd0);
      chk("rst2_drop", 32'(drop_out), 32'd0);
      chk("rst2_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst2_busy", 32'(busy_out), 32'd0);

      // Ping-pong continuity: a strobe every 7 cycles for 10 frames
      for (int i = 0; i < 10 * FL; i++) begin
         strobe(8'(7 * i + 3), 1'b1);
         idle(6);
      end
      drain(10 * FL, 100);
      check_beats("pp");
      chk("pp_frames", 32'(frame_count_out), 32'd10);
      chk("pp_drop", 32'(drop_out), 32'd0);

      // Partial discard: 5 samples thrown away by a one-cycle enable drop
      for (int i = 0; i < 5; i++) strobe(8'(200 + i), 1'b0);
      enable_in = 1'b0;
      tick();
      enable_in = 1'b1;
      for (int i = 0; i < FL; i++) strobe(8'(8'h40 + i), 1'b1);
      drain(FL, 60);
      check_beats("partial");
      chk("partial_frames", 32'(frame_count_out), 32'd11);

      // Reset while beat 7 is on the bus
      for (int i = 0; i < FL; i++) strobe(8'(9 * i), 1'b1);
      begin
         int b = 0;
         while (got_data.size() < 7 && b < 60) begin
            tick();
            b++;
         end
      end
      chk("mid_reached_beat7", 32'(got_data.size()), 32'd7);
      m_axis_tready = 1'b0;
      rst_in        = 1'b1;
      tick();
      rst_in        = 1'b0;
      chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("mid_rst_frames", 32'(frame_count_out), 32'd0);
      chk("mid_rst_drop", 32'(drop_out), 32'd0);
      expq.delete();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
      m_axis_tready = 1'b1;
      idle(4);
      chk("mid_rst_quiet", 32'(got_data.size()), 32'd0);
      for (int i = 0; i < FL; i++) strobe(8'(8'h80 + i), 1'b1);
      drain(FL, 60);
      check_beats("post_rst");
      chk("post_rst_frames", 32'(frame_count_out), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
